// File: rtl/ex_stage_if.sv
// ex_stage_if: ID/EX operands and control, forwarding selects and EX/MEM register outputs of ex_stage
interface ex_stage_if #(
  parameter int XLEN = 32
);
  logic            id_ex_valid;
  logic [XLEN-1:0] id_ex_pc, id_ex_rs1_data, id_ex_rs2_data, id_ex_imm;
  logic [3:0]      id_ex_alu_op;
  logic            id_ex_alu_src, id_ex_is_md;
  logic [2:0]      id_ex_md_op;
  logic [4:0]      id_ex_rd;
  logic            id_ex_reg_write, id_ex_mem_read, id_ex_mem_write;
  logic [1:0]      forward_a, forward_b;
  logic [XLEN-1:0] mem_wb_wdata;
  logic            ex_busy;
  logic            ex_mem_valid, ex_mem_reg_write, ex_mem_mem_read, ex_mem_mem_write;
  logic [XLEN-1:0] ex_mem_alu_result, ex_mem_store_data;
  logic [4:0]      ex_mem_rd;
  modport master (
    output id_ex_valid, id_ex_pc, id_ex_rs1_data, id_ex_rs2_data, id_ex_imm, id_ex_alu_op,
           id_ex_alu_src, id_ex_is_md, id_ex_md_op, id_ex_rd, id_ex_reg_write, id_ex_mem_read,
           id_ex_mem_write, forward_a, forward_b, mem_wb_wdata,
    input  ex_busy, ex_mem_valid, ex_mem_reg_write, ex_mem_mem_read, ex_mem_mem_write,
           ex_mem_alu_result, ex_mem_store_data, ex_mem_rd
  );
  modport slave (
    input  id_ex_valid, id_ex_pc, id_ex_rs1_data, id_ex_rs2_data, id_ex_imm, id_ex_alu_op,
           id_ex_alu_src, id_ex_is_md, id_ex_md_op, id_ex_rd, id_ex_reg_write, id_ex_mem_read,
           id_ex_mem_write, forward_a, forward_b, mem_wb_wdata,
    output ex_busy, ex_mem_valid, ex_mem_reg_write, ex_mem_mem_read, ex_mem_mem_write,
           ex_mem_alu_result, ex_mem_store_data, ex_mem_rd
  );
endinterface

// File: rtl/ex_stage.sv
// ex_stage: RV32 execute stage with EX/MEM register; ports clk, rst, bus (ex_stage_if.slave); RV_MULDIV_EN adds the iterative mul/div unit
module ex_stage #(
  parameter int XLEN = 32
) (
  input logic       clk,
  input logic       rst,
  ex_stage_if.slave bus
);
  logic [XLEN-1:0] a, rs2, b, alu, res;
  logic busy;
  assign a = bus.forward_a == 2'b10 ? bus.ex_mem_alu_result : bus.forward_a == 2'b01 ? bus.mem_wb_wdata : bus.id_ex_rs1_data;
  assign rs2 = bus.forward_b == 2'b10 ? bus.ex_mem_alu_result : bus.forward_b == 2'b01 ? bus.mem_wb_wdata : bus.id_ex_rs2_data;
  assign b = bus.id_ex_alu_src ? bus.id_ex_imm : rs2;
  always_comb begin
    alu = '0;
    case (bus.id_ex_alu_op)
      4'h0: alu = a + b;
      4'h1: alu = a - b;
      4'h2: alu = a & b;
      4'h3: alu = a | b;
      4'h4: alu = a ^ b;
      4'h5: alu = a << b[4:0];
      4'h6: alu = a >> b[4:0];
      4'h7: alu = $unsigned($signed(a) >>> b[4:0]);
      4'h8: alu = XLEN'($signed(a) < $signed(b));
      4'h9: alu = XLEN'(a < b);
      4'ha: alu = b;
      4'hb: alu = bus.id_ex_pc + b;
      4'hc: alu = bus.id_ex_pc + XLEN'(4);
      default: alu = '0;
    endcase
  end
`ifdef RV_MULDIV_EN
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state;
  logic [5:0] cnt;
  logic [2:0] op, cur_op;
  logic [XLEN-1:0] ra, rb, m, ca, cb, ma, mb, diff, quo, rem;
  logic [2*XLEN-1:0] acc, prod;
  logic [XLEN:0] sum, sh;
  logic start, na, nb, ge;
  assign start = state == IDLE && bus.id_ex_valid && bus.id_ex_is_md;
  assign busy = start || state == CALC;
  assign cur_op = state == IDLE ? bus.id_ex_md_op : op;
  assign ca = state == IDLE ? a : ra;
  assign cb = state == IDLE ? rs2 : rb;
  assign na = ca[XLEN-1] && (cur_op == 3'd1 || cur_op == 3'd2 || cur_op == 3'd4 || cur_op == 3'd6);
  assign nb = cb[XLEN-1] && (cur_op == 3'd1 || cur_op == 3'd4 || cur_op == 3'd6);
  assign ma = na ? -ca : ca;
  assign mb = nb ? -cb : cb;
  // multiply: acc = {partial product, remaining multiplier bits}; divide: acc = {remainder, dividend/quotient bits}
  assign sum = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, acc[0] ? m : {XLEN{1'b0}}};
  assign sh = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
  assign ge = sh >= {1'b0, m};
  assign diff = sh[XLEN-1:0] - m;
  assign prod = (na ^ nb) ? -acc : acc;
  assign quo = rb == '0 ? '1 : (na ^ nb) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
  assign rem = rb == '0 ? ra : na ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
  assign res = state != DONE ? alu : op[2] ? (op[1] ? rem : quo) : op[1:0] == 2'b00 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      op <= '0;
      ra <= '0;
      rb <= '0;
      m <= '0;
      acc <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state <= CALC;
          cnt <= '0;
          op <= bus.id_ex_md_op;
          ra <= a;
          rb <= rs2;
          m <= bus.id_ex_md_op[2] ? mb : ma;
          acc <= {{XLEN{1'b0}}, bus.id_ex_md_op[2] ? ma : mb};
        end
        CALC: begin
          cnt <= cnt + 6'd1;
          acc <= op[2] ? {ge ? diff : sh[XLEN-1:0], acc[XLEN-2:0], ge} : {sum, acc[XLEN-1:1]};
          if (cnt == 6'd31) state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end
`else
  logic unused_md;
  assign unused_md = ^bus.id_ex_md_op;
  assign busy = 1'b0;
  assign res = bus.id_ex_is_md ? '0 : alu;
`endif
  assign bus.ex_busy = busy;
  always_ff @(posedge clk) begin
    if (rst || busy) begin
      bus.ex_mem_valid <= 1'b0;
      bus.ex_mem_reg_write <= 1'b0;
      bus.ex_mem_mem_read <= 1'b0;
      bus.ex_mem_mem_write <= 1'b0;
      bus.ex_mem_alu_result <= '0;
      bus.ex_mem_store_data <= '0;
      bus.ex_mem_rd <= '0;
    end else begin
      bus.ex_mem_valid <= bus.id_ex_valid;
      bus.ex_mem_reg_write <= bus.id_ex_valid && bus.id_ex_reg_write;
      bus.ex_mem_mem_read <= bus.id_ex_valid && bus.id_ex_mem_read;
      bus.ex_mem_mem_write <= bus.id_ex_valid && bus.id_ex_mem_write;
      bus.ex_mem_alu_result <= res;
      bus.ex_mem_store_data <= rs2;
      bus.ex_mem_rd <= bus.id_ex_rd;
    end
  end
endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the 5-stage RV32 pipeline. Sits between the ID/EX register and the EX/MEM register, downstream of the forwarding unit. It:
- applies `forward_a`/`forward_b` to select operands;
- computes the ALU result, or runs an optional iterative multiply/divide unit;
- owns the EX/MEM pipeline register.

It stalls the front of the pipeline with `ex_busy` while a multi-cycle M-extension operation runs.

## Interface
Parameters:
- `XLEN`, 32, datapath width (only 32 supported)

Ports:
- `clk`  in  1  pipeline clock, all state on rising edge
- `rst`  in  1  synchronous, active-high reset
- `id_ex_valid`  in  1  EX holds a real instruction
- `id_ex_pc`  in  XLEN  instruction PC
- `id_ex_rs1_data` / `id_ex_rs2_data`  in  XLEN  register-file operands
- `id_ex_imm`  in  XLEN  sign-extended immediate
- `id_ex_alu_op`  in  4  ALU operation code (see Operation)
- `id_ex_alu_src`  in  1  1 = operand B is `id_ex_imm`
- `id_ex_is_md`  in  1  M-extension instruction
- `id_ex_md_op`  in  3  funct3 of the M instruction
- `id_ex_rd`  in  5  destination register
- `id_ex_reg_write`, `id_ex_mem_read`, `id_ex_mem_write`  in  1 each  control bits
- `forward_a` / `forward_b`  in  2  forwarding select: 00 = register file, 10 = `ex_mem_alu_result`, 01 = `mem_wb_wdata`
- `mem_wb_wdata`  in  XLEN  write-back data
- `ex_busy`  out  1  stall request to PC, IF/ID and ID/EX
- `ex_mem_valid`, `ex_mem_reg_write`, `ex_mem_mem_read`, `ex_mem_mem_write`  out  1 each  registered control
- `ex_mem_alu_result`  out  XLEN  registered result, also the forwarding source
- `ex_mem_store_data`  out  XLEN  registered forwarded rs2
- `ex_mem_rd`  out  5  registered destination

## Operation
- Operand A is the forwarded rs1. The forwarded rs2 is captured as store data.
- Operand B is `id_ex_imm` when `id_ex_alu_src` = 1, else the forwarded rs2.
- A `forward_*` code of 11 is treated as 00.
- ALU op codes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR
  - 5 SLL, 6 SRL, 7 SRA (shift amount = B[4:0])
  - 8 SLT, 9 SLTU (result 0/1)
  - A pass-B (LUI), B `pc` + B (AUIPC), C `pc` + 4 (JAL/JALR link)
  - D–F produce 0
- Arithmetic wraps modulo 2^32.
- Non-MD instruction, or `id_ex_valid` = 0: the EX/MEM register loads every cycle. Control bits are ANDed with `id_ex_valid`, so `ex_mem_valid` = `id_ex_valid`.
- MD FSM states: IDLE, CALC, DONE.
  - IDLE, with `id_ex_valid` and `id_ex_is_md` both 1:
    - `ex_busy` = 1 combinationally;
    - the forwarded operands and `md_op` are latched;
    - counter cleared; next state CALC.
  - CALC: one bit per cycle. Shift-add for MUL/MULH/MULHSU/MULHU; restoring divide on magnitudes for DIV/DIVU/REM/REMU. After 32 cycles, next state DONE.
  - DONE: `ex_busy` = 0; the fixed-up result loads EX/MEM; next state IDLE.
- Result fixups:
  - MUL returns the low word; the MULH variants return the high word with signedness per funct3.
  - Quotient negated when operand signs differ; remainder takes the sign of the dividend.
  - Divide by zero: quotient 0xFFFFFFFF, remainder = dividend.
  - DIV of 0x80000000 by 0xFFFFFFFF: quotient 0x80000000, remainder 0.
- While `ex_busy` = 1, EX/MEM loads a bubble (all control bits 0, data 0). Upstream holds ID/EX stable.

## Timing
- Reset: FSM IDLE, counter 0, `ex_busy` 0, all `ex_mem_*` outputs 0.
- Reset mid-CALC: the operation is abandoned and the same reset values apply on the next edge.
- ALU ops: 1-cycle latency. The result is visible on `ex_mem_*` after the edge that ends the EX cycle.
- MD ops: the instruction enters EX in cycle T.
  - `ex_busy` = 1 during cycles T through T+32.
  - DONE occurs in cycle T+33.
  - The result appears on `ex_mem_*` after the edge that ends T+33.
  - Total EX occupancy is 34 cycles; EX/MEM carries bubbles for T..T+32.
- Operands are sampled only in cycle T, so writebacks completing during CALC do not alter the operation.
- Back-to-back MD: the second instruction enters at T+34 and is accepted from IDLE with no extra gap.

## Configuration
- `RV_MULDIV_EN` defined: the MD FSM and datapath are present, as described above.
- `RV_MULDIV_EN` undefined: no FSM, `ex_busy` is tied to 0, and any `id_ex_is_md` instruction completes in 1 cycle with result 0. Control bits pass through unchanged.

## Test plan
- ADD x3 with A = 5, B = 7, `forward_*` = 00 → next cycle `ex_mem_alu_result` = 12, `ex_mem_valid` = 1.
- `forward_a` = 10 with previous result 0x10, then `forward_a` = 01 with `mem_wb_wdata` = 0x20; ADD with imm 1 → results 0x11 then 0x21.
- SRA with A = 0x80000000, B = 4 → 0xF8000000. SLTU with A = 1, B = 0xFFFFFFFF → 1.
- DIV with A = 0xFFFFFFF9 (−7), B = 2 → `ex_busy` high 33 cycles, 33 bubbles, then result 0xFFFFFFFD (−3). REM of the same operands → 0xFFFFFFFF (−1).
- DIVU with B = 0 → 0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF → 0x80000000. MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
- Assert `rst` at cycle T+10 of a MUL → next cycle `ex_busy` = 0, all `ex_mem_*` = 0. A following ADD completes in 1 cycle.
